// File: rtl/pwm_breathe_sequencer.sv
// Breathing/steady duty sequencer for a PWM datapath: produces a registered duty code
// that ramps between 0 and ref_duty with programmable step rate and peak/trough dwell.
module pwm_breathe_sequencer #(
    parameter int DUTY_W = 6,
    parameter int DIV_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              enable_pwm,
    input  logic              breathe_en,
    input  logic [DUTY_W-1:0] ref_duty,
    input  logic [DIV_W-1:0]  step_div,
    input  logic [DIV_W-1:0]  hold_periods,
    input  logic              period_end,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_load,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STEADY    = 3'd1,
        RAMP_UP   = 3'd2,
        HOLD_HIGH = 3'd3,
        RAMP_DOWN = 3'd4,
        HOLD_LOW  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DIV_W-1:0]  pre_q, pre_d;
    logic [DIV_W-1:0]  hold_q, hold_d;
    logic              load_q;
    logic              tick;

    assign tick = ena & period_end & enable_pwm;

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        pre_d   = pre_q;
        hold_d  = hold_q;
        if (ena && !enable_pwm) begin
            state_d = IDLE;
            duty_d  = '0;
            pre_d   = '0;
            hold_d  = '0;
        end else if (tick) begin
            case (state_q)
                IDLE: begin
                    if (breathe_en) begin
                        state_d = RAMP_UP;
                        duty_d  = '0;
                    end else begin
                        state_d = STEADY;
                        duty_d  = ref_duty;
                    end
                end
                STEADY: begin
                    if (breathe_en) state_d = RAMP_UP;
                    else            duty_d  = ref_duty;
                end
                default: begin
                    if (!breathe_en) begin
                        state_d = STEADY;
                        duty_d  = ref_duty;
                    end else begin
                        // >= rather than == so a live shrink of step_div/hold_periods
                        // below the running count fires at once instead of wrapping.
                        case (state_q)
                            RAMP_UP: begin
                                if (duty_q >= ref_duty) begin
                                    state_d = HOLD_HIGH;
                                    duty_d  = ref_duty;
                                end else if (pre_q >= step_div) begin
                                    pre_d  = '0;
                                    duty_d = duty_q + DUTY_W'(1);
                                    if (duty_q + DUTY_W'(1) == ref_duty) state_d = HOLD_HIGH;
                                end else begin
                                    pre_d = pre_q + DIV_W'(1);
                                end
                            end
                            HOLD_HIGH: begin
                                if (hold_q >= hold_periods) state_d = RAMP_DOWN;
                                else                        hold_d  = hold_q + DIV_W'(1);
                            end
                            RAMP_DOWN: begin
                                if (duty_q == '0) begin
                                    state_d = HOLD_LOW;
                                end else if (pre_q >= step_div) begin
                                    pre_d  = '0;
                                    duty_d = duty_q - DUTY_W'(1);
                                    if (duty_q == DUTY_W'(1)) state_d = HOLD_LOW;
                                end else begin
                                    pre_d = pre_q + DIV_W'(1);
                                end
                            end
                            HOLD_LOW: begin
                                if (hold_q >= hold_periods) state_d = RAMP_UP;
                                else                        hold_d  = hold_q + DIV_W'(1);
                            end
                            default: state_d = IDLE;
                        endcase
                    end
                end
            endcase
            if (state_d != state_q) begin
                pre_d  = '0;
                hold_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            duty_q  <= '0;
            pre_q   <= '0;
            hold_q  <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            pre_q   <= pre_d;
            hold_q  <= hold_d;
            load_q  <= (duty_d != duty_q);
        end
    end

    assign duty      = duty_q;
    assign duty_load = load_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pwm_breathe_sequencer.sv
// Directed self-checking bench for pwm_breathe_sequencer with hand-computed duty/state sequences.
module tb_pwm_breathe_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic       enable_pwm = 1'b0;
    logic       breathe_en = 1'b0;
    logic [5:0] ref_duty = '0;
    logic [3:0] step_div = '0;
    logic [3:0] hold_periods = '0;
    logic       period_end = 1'b0;
    logic [5:0] duty;
    logic       duty_load;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;

    int d33 [10] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1};
    int s33 [10] = '{2, 2, 2, 3, 4, 4, 4, 5, 2, 2};
    int l33 [10] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 1};
    int d34 [17] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 2};
    int s34 [17] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 4};
    int l34 [17] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    int s27 [5]  = '{2, 3, 4, 5, 2};

    always #5 clk = ~clk;

    pwm_breathe_sequencer #(.DUTY_W(6), .DIV_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .enable_pwm   (enable_pwm),
        .breathe_en   (breathe_en),
        .ref_duty     (ref_duty),
        .step_div     (step_div),
        .hold_periods (hold_periods),
        .period_end   (period_end),
        .duty         (duty),
        .duty_load    (duty_load),
        .state        (state)
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input int st, input int du, input int ld);
        check({tag, ".state"}, int'(state), st);
        check({tag, ".duty"}, int'(duty), du);
        check({tag, ".load"}, int'(duty_load), ld);
        $display("[TB] %s: state=%0d duty=%0d load=%0d", tag, state, duty, duty_load);
    endtask

    // One clock: drive period_end at the falling edge, sample 1 time unit after the rising edge.
    task automatic cyc(input logic pe);
        @(negedge clk);
        period_end = pe;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset acts without a clock edge
        #2 rst_n = 1'b0;
        #1 chk3("reset", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Steady single tick
        enable_pwm = 1'b1; ref_duty = 6'd6;
        cyc(1'b0); chk3("steady_notick", 0, 0, 0);
        cyc(1'b1); chk3("steady_tick", 1, 6, 1);
        cyc(1'b0); chk3("steady_after", 1, 6, 0);

        // Disable from STEADY, then breathe ref=3 step=0 hold=0 with period_end held high
        enable_pwm = 1'b0;
        cyc(1'b0); chk3("disable_steady", 0, 0, 1);
        enable_pwm = 1'b1; breathe_en = 1'b1; ref_duty = 6'd3;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1);
            chk3($sformatf("br33_t%0d", i), s33[i], d33[i], l33[i]);
        end

        // step_div=2, hold_periods=3 with single-cycle ticks
        enable_pwm = 1'b0;
        cyc(1'b0); chk3("disable_br33", 0, 0, 1);
        enable_pwm = 1'b1; step_div = 4'd2; hold_periods = 4'd3;
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1);
            chk3($sformatf("br34_t%0d", i), s34[i], d34[i], l34[i]);
            cyc(1'b0);
        end

        // Drop enable_pwm mid-ramp at duty 10 with no period_end
        enable_pwm = 1'b0;
        cyc(1'b0); chk3("disable_br34", 0, 0, 1);
        enable_pwm = 1'b1; ref_duty = 6'd32; step_div = 4'd0;
        for (int i = 0; i < 11; i++) cyc(1'b1);
        chk3("ramp_at10", 2, 10, 1);
        enable_pwm = 1'b0;
        cyc(1'b0); chk3("drop_enable", 0, 0, 1);

        // Lower ref_duty below current duty mid-ramp
        enable_pwm = 1'b1;
        for (int i = 0; i < 21; i++) cyc(1'b1);
        chk3("ramp_at20", 2, 20, 1);
        ref_duty = 6'd16;
        cyc(1'b1); chk3("ref_lowered", 3, 16, 1);

        // ena=0 freezes state and counters (hold count at 1 of 3)
        cyc(1'b1); chk3("hold_cnt1", 3, 16, 0);
        ena = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc(1'b1);
            check($sformatf("frozen_load_%0d", i), int'(duty_load), 0);
        end
        chk3("frozen_end", 3, 16, 0);
        ena = 1'b1;
        cyc(1'b1); chk3("resume_hold2", 3, 16, 0);
        cyc(1'b1); chk3("resume_hold3", 3, 16, 0);
        cyc(1'b1); chk3("resume_rd", 4, 16, 0);
        cyc(1'b1); chk3("rd_15", 4, 15, 1);
        cyc(1'b1); chk3("rd_14", 4, 14, 1);

        // Asynchronous reset mid-ramp, visible before the next clock edge
        #2 rst_n = 1'b0;
        #1 chk3("async_reset", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1; breathe_en = 1'b0; ref_duty = 6'd5;
        period_end = 1'b0;
        cyc(1'b0); chk3("post_reset_idle", 0, 0, 0);
        cyc(1'b1); chk3("post_reset_tick", 1, 5, 1);

        // STEADY -> RAMP_UP keeps duty; already at ref -> HOLD_HIGH; breathe_en=0 -> STEADY
        breathe_en = 1'b1;
        cyc(1'b1); chk3("steady_to_ru", 2, 5, 0);
        cyc(1'b1); chk3("ru_at_ref", 3, 5, 0);
        breathe_en = 1'b0; ref_duty = 6'd7;
        cyc(1'b1); chk3("breathe_off", 1, 7, 1);

        // ref_duty=0 breathing cycles states with duty stuck at 0
        enable_pwm = 1'b0;
        cyc(1'b0); chk3("disable_steady7", 0, 0, 1);
        enable_pwm = 1'b1; breathe_en = 1'b1; ref_duty = 6'd0; hold_periods = 4'd0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1);
            chk3($sformatf("zero_ref_t%0d", i), s27[i], 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
